// File: rtl/coin_return_dispenser_pkg.sv
// Shared vending-machine definitions: coin denominations, their one-hot
// tray encodings, datapath widths and the payout FSM state codes.
package coin_return_dispenser_pkg;

    localparam int kNumCoins     = 3;
    localparam int kBalanceWidth = 32;
    localparam int kCountWidth   = 16;

    localparam logic [kBalanceWidth-1:0] kValue100  = 32'd100;
    localparam logic [kBalanceWidth-1:0] kValue500  = 32'd500;
    localparam logic [kBalanceWidth-1:0] kValue1000 = 32'd1000;

    // One-hot coin bus: bit0=100, bit1=500, bit2=1000.
    localparam logic [kNumCoins-1:0] kCoinNone = 3'b000;
    localparam logic [kNumCoins-1:0] kCoin100  = 3'b001;
    localparam logic [kNumCoins-1:0] kCoin500  = 3'b010;
    localparam logic [kNumCoins-1:0] kCoin1000 = 3'b100;

    localparam logic [kCountWidth-1:0] kCountZero = '0;
    localparam logic [kCountWidth-1:0] kCountOne  = 16'd1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] DISPENSE = 2'd1;
    localparam logic [1:0] DONE     = 2'd2;

    // Result of picking the next coin for a given remaining amount.
    typedef struct packed {
        logic [kNumCoins-1:0]     coin;
        logic [kBalanceWidth-1:0] value;
        logic                     valid;
    } coin_pick_t;

endpackage

// File: rtl/coin_return_dispenser_coin_select.sv
// Greedy coin picker: largest denomination not exceeding the remaining
// amount. valid is low once less than the smallest coin is left.
module coin_select
    import coin_return_dispenser_pkg::*;
(
    input  logic [kBalanceWidth-1:0] remaining,
    output coin_pick_t               pick
);

    // Largest-first priority chain over the three denominations.
    always_comb begin
        pick.coin  = kCoinNone;
        pick.value = '0;
        pick.valid = 1'b0;
        if (remaining >= kValue1000) begin
            pick.coin  = kCoin1000;
            pick.value = kValue1000;
            pick.valid = 1'b1;
        end else if (remaining >= kValue500) begin
            pick.coin  = kCoin500;
            pick.value = kValue500;
            pick.valid = 1'b1;
        end else if (remaining >= kValue100) begin
            pick.coin  = kCoin100;
            pick.value = kValue100;
            pick.valid = 1'b1;
        end
    end

endmodule

// File: rtl/coin_return_dispenser.sv
// Change payout engine: latches the balance on start, then emits one coin
// per tray-ready cycle (largest first) and reports the undispensable rest.
module coin_return_dispenser
    import coin_return_dispenser_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    input  logic [kBalanceWidth-1:0] i_balance,
    input  logic                     i_tray_ready,
    output logic [kNumCoins-1:0]     o_return_coin,
    output logic                     o_busy,
    output logic                     o_done,
    output logic [kBalanceWidth-1:0] o_residual,
    output logic [kCountWidth-1:0]   o_count_1000,
    output logic [kCountWidth-1:0]   o_count_500,
    output logic [kCountWidth-1:0]   o_count_100
);

    logic [1:0]               state;
    logic [kBalanceWidth-1:0] remaining;
    coin_pick_t               pick;

    coin_select u_coin_select (
        .remaining (remaining),
        .pick      (pick)
    );

    // Busy covers the whole payout including the completion cycle.
    assign o_busy = (state == DISPENSE) || (state == DONE);

    // Payout FSM, remaining-amount register and per-denomination counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            remaining     <= '0;
            o_return_coin <= kCoinNone;
            o_done        <= 1'b0;
            o_residual    <= '0;
            o_count_1000  <= kCountZero;
            o_count_500   <= kCountZero;
            o_count_100   <= kCountZero;
        end else begin
            case (state)
                IDLE: begin
                    o_return_coin <= kCoinNone;
                    o_done        <= 1'b0;
                    if (i_start) begin
                        remaining    <= i_balance;
                        o_residual   <= '0;
                        o_count_1000 <= kCountZero;
                        o_count_500  <= kCountZero;
                        o_count_100  <= kCountZero;
                        state        <= DISPENSE;
                    end
                end
                DISPENSE: begin
                    if (!pick.valid) begin
                        // Nothing payable left: publish the leftover and finish.
                        o_return_coin <= kCoinNone;
                        o_residual    <= remaining;
                        o_done        <= 1'b1;
                        state         <= DONE;
                    end else if (!i_tray_ready) begin
                        o_return_coin <= kCoinNone;
                    end else begin
                        o_return_coin <= pick.coin;
                        remaining     <= remaining - pick.value;
                        if (pick.coin == kCoin1000) o_count_1000 <= o_count_1000 + kCountOne;
                        if (pick.coin == kCoin500)  o_count_500  <= o_count_500  + kCountOne;
                        if (pick.coin == kCoin100)  o_count_100  <= o_count_100  + kCountOne;
                    end
                end
                DONE: begin
                    o_return_coin <= kCoinNone;
                    o_done        <= 1'b0;
                    state         <= IDLE;
                end
                default: begin
                    o_return_coin <= kCoinNone;
                    o_done        <= 1'b0;
                    state         <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_coin_return_dispenser.sv
// Bench for coin_return_dispenser: directed scenarios plus random traffic,
// all checked every cycle against a queue-based payout model.
module tb_coin_return_dispenser;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [31:0] i_balance = '0;
    logic        i_tray_ready = 1'b1;
    logic [2:0]  o_return_coin;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_residual;
    logic [15:0] o_count_1000;
    logic [15:0] o_count_500;
    logic [15:0] o_count_100;

    coin_return_dispenser dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_balance     (i_balance),
        .i_tray_ready  (i_tray_ready),
        .o_return_coin (o_return_coin),
        .o_busy        (o_busy),
        .o_done        (o_done),
        .o_residual    (o_residual),
        .o_count_1000  (o_count_1000),
        .o_count_500   (o_count_500),
        .o_count_100   (o_count_100)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model: the payout is precomputed as a list of coin values at start.
    int          pending[$];
    bit          active = 0;
    bit          done_cyc = 0;
    int          pend_resid = 0;
    logic [2:0]  m_coin = 0;
    logic        m_done = 0;
    logic [31:0] m_resid = 0;
    int          c1000 = 0, c500 = 0, c100 = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_edge();
        int amt;
        int v;
        if (reset) begin
            pending.delete();
            active = 0; done_cyc = 0; m_coin = 0; m_done = 0; m_resid = 0;
            c1000 = 0; c500 = 0; c100 = 0;
        end else if (done_cyc) begin
            done_cyc = 0; m_done = 0; m_coin = 0;
        end else if (active) begin
            if (pending.size() == 0) begin
                active = 0; done_cyc = 1; m_done = 1; m_coin = 0;
                m_resid = pend_resid;
            end else if (!i_tray_ready) begin
                m_coin = 0;
            end else begin
                v = pending.pop_front();
                if (v == 1000) begin m_coin = 3'b100; c1000++; end
                else if (v == 500) begin m_coin = 3'b010; c500++; end
                else begin m_coin = 3'b001; c100++; end
            end
        end else begin
            m_coin = 0;
            if (i_start) begin
                amt = int'(i_balance);
                repeat (amt / 1000) pending.push_back(1000);
                amt = amt % 1000;
                repeat (amt / 500) pending.push_back(500);
                amt = amt % 500;
                repeat (amt / 100) pending.push_back(100);
                pend_resid = amt % 100;
                c1000 = 0; c500 = 0; c100 = 0; m_resid = 0;
                active = 1;
            end
        end
    endtask

    // One clock: update model, let the edge happen, compare all outputs.
    task automatic cyc();
        model_edge();
        @(posedge clk);
        #1;
        chk("coin",     {61'd0, o_return_coin}, {61'd0, m_coin});
        chk("busy",     {63'd0, o_busy},        {63'd0, (active || done_cyc)});
        chk("done",     {63'd0, o_done},        {63'd0, m_done});
        chk("residual", {32'd0, o_residual},    {32'd0, m_resid});
        chk("cnt1000",  {48'd0, o_count_1000},  64'(c1000));
        chk("cnt500",   {48'd0, o_count_500},   64'(c500));
        chk("cnt100",   {48'd0, o_count_100},   64'(c100));
    endtask

    task automatic start(input int bal);
        i_balance = 32'(bal);
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        cyc(); cyc();
        reset = 1'b0;
        chk("rst_coin", {61'd0, o_return_coin}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_resid", {32'd0, o_residual}, 64'd0);

        // 1700, tray always ready
        start(1700);
        cyc(); chk("p1700_e1", {61'd0, o_return_coin}, 64'b100);
        cyc(); chk("p1700_e2", {61'd0, o_return_coin}, 64'b010);
        cyc(); chk("p1700_e3", {61'd0, o_return_coin}, 64'b001);
        cyc(); chk("p1700_e4", {61'd0, o_return_coin}, 64'b001);
        cyc(); chk("p1700_done", {63'd0, o_done}, 64'd1);
        chk("p1700_resid", {32'd0, o_residual}, 64'd0);
        chk("p1700_c1000", {48'd0, o_count_1000}, 64'd1);
        chk("p1700_c500", {48'd0, o_count_500}, 64'd1);
        chk("p1700_c100", {48'd0, o_count_100}, 64'd2);
        cyc(); chk("p1700_idle", {63'd0, o_busy}, 64'd0);

        // 150: one coin, residual 50 held
        start(150);
        cyc(); chk("p150_e1", {61'd0, o_return_coin}, 64'b001);
        cyc(); chk("p150_done", {63'd0, o_done}, 64'd1);
        chk("p150_resid", {32'd0, o_residual}, 64'd50);
        cyc(); cyc(); cyc();
        chk("p150_hold", {32'd0, o_residual}, 64'd50);

        // 0: immediate done, no coin
        start(0);
        cyc(); chk("p0_done", {63'd0, o_done}, 64'd1);
        chk("p0_coin", {61'd0, o_return_coin}, 64'd0);
        cyc();

        // 600 with tray stalled over E1..E3, stray start during stall
        i_tray_ready = 1'b0;
        start(600);
        i_balance = 32'd2000;
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
        cyc(); cyc();
        chk("p600_stall", {61'd0, o_return_coin}, 64'd0);
        i_tray_ready = 1'b1;
        cyc(); chk("p600_e4", {61'd0, o_return_coin}, 64'b010);
        cyc(); chk("p600_e5", {61'd0, o_return_coin}, 64'b001);
        cyc(); chk("p600_done", {63'd0, o_done}, 64'd1);
        cyc();

        // 3000 aborted by reset after the first coin
        start(3000);
        cyc();
        chk("p3000_e1", {61'd0, o_return_coin}, 64'b100);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("abort_coin", {61'd0, o_return_coin}, 64'd0);
        chk("abort_busy", {63'd0, o_busy}, 64'd0);
        chk("abort_c1000", {48'd0, o_count_1000}, 64'd0);
        start(100);
        cyc(); chk("after_abort", {61'd0, o_return_coin}, 64'b001);
        cyc(); cyc();

        // Back-to-back: start during done pulse ignored, later accepted
        start(500);
        cyc(); cyc();
        chk("b2b_done", {63'd0, o_done}, 64'd1);
        i_balance = 32'd500;
        i_start = 1'b1;
        cyc();
        chk("b2b_ignored", {63'd0, o_busy}, 64'd0);
        cyc();
        i_start = 1'b0;
        chk("b2b_accepted", {63'd0, o_busy}, 64'd1);
        cyc(); chk("b2b_coin", {61'd0, o_return_coin}, 64'b010);
        cyc(); cyc();

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset        = ($urandom_range(0, 199) == 0);
            i_start      = ($urandom_range(0, 3) == 0);
            i_tray_ready = ($urandom_range(0, 3) != 0);
            i_balance    = 32'($urandom_range(0, 4999));
            cyc();
        end
        reset = 1'b0;
        i_start = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
